vector_streamer: RTL and testbench
==================================

VECTOR_STREAMER -- requirements
Module: vector_streamer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, bit width of one element.
REQ-002 Parameter IN_DIM, default 3, elements per vector.
REQ-003 Parameter ADDR_WIDTH, default 8, activation-memory address width.
REQ-004 Parameter CNT_WIDTH, default 8, width of the vector-count fields.
REQ-005 Port clk, input, 1 -- single clock; all state updates on posedge clk.
REQ-006 Port rst_n, input, 1 -- reset, asynchronous, active-low.
REQ-007 Port start, input, 1 -- launches one job when sampled high in IDLE.
REQ-008 Port abort, input, 1 -- synchronous job cancel.
REQ-009 Port base_addr, input, ADDR_WIDTH -- first element address; sampled with start.
REQ-010 Port num_vectors, input, CNT_WIDTH -- vectors in the job; sampled with start.
REQ-011 Port mem_rd_en, output, 1 -- memory read strobe.
REQ-012 Port mem_addr, output, ADDR_WIDTH -- memory read address.
REQ-013 Port mem_rd_data, input, DATA_WIDTH -- read data, valid the cycle after the strobe is sampled.
REQ-014 Port ready, input, 1 -- downstream feeder can accept a vector.
REQ-015 Port vector_valid, output, 1 -- vector_out holds a vector.
REQ-016 Port vector_out, output, IN_DIM*DATA_WIDTH -- packed vector; element k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-017 Port vectors_complete, output, 1 -- one-cycle pulse after the last transfer.
REQ-018 Port busy, output, 1 -- high in every state except IDLE.
REQ-019 Port vec_count, output, CNT_WIDTH -- vectors transferred in the current job.

Function
REQ-020 FSM states: IDLE, FETCH, PRESENT, COMPLETE.
REQ-021 IDLE -> FETCH when start=1 and num_vectors!=0; base_addr, num_vectors latched; vec_count cleared to 0.
REQ-022 IDLE -> COMPLETE when start=1 and num_vectors==0; no memory reads.
REQ-023 FETCH: mem_rd_en=1 for exactly IN_DIM consecutive cycles at addresses A, A+1, ..., A+IN_DIM-1, where A = base + vec_count*IN_DIM.
REQ-024 Address arithmetic is modulo 2^ADDR_WIDTH; wrap past the top address is legal and silent.
REQ-025 Data for read k is captured into element slot k one cycle after that read is issued.
REQ-026 FETCH -> PRESENT on the edge that captures element IN_DIM-1.
REQ-027 vector_valid rises IN_DIM+1 cycles after the edge that sampled start.
REQ-028 PRESENT: vector_valid=1; vector_out is held stable until transfer.
REQ-029 A transfer occurs on a posedge where vector_valid=1 and ready=1; vec_count increments on that edge.
REQ-030 After a transfer: -> FETCH if vec_count+1 < num_vectors, else -> COMPLETE; vector_valid=0 the next cycle.
REQ-031 COMPLETE lasts exactly one cycle with vectors_complete=1, then -> IDLE.
REQ-032 vector_valid and vectors_complete are never high in the same cycle.
REQ-033 mem_rd_en=0 outside FETCH; mem_addr holds its last value.
REQ-034 start is ignored while busy=1.
REQ-035 abort=1 in any non-IDLE state: -> IDLE on that edge; vector_valid=0, mem_rd_en=0, no vectors_complete pulse; vec_count holds.
REQ-036 abort has priority over a simultaneous transfer; that vector counts as not transferred.
REQ-037 abort in IDLE has no effect; simultaneous start+abort in IDLE -> no job started.
REQ-038 vector_out is cleared to 0 when a job starts.

Reset
REQ-039 rst_n=0 forces immediately, regardless of clk: state=IDLE; vector_valid, vectors_complete, mem_rd_en, busy=0; vector_out, mem_addr, vec_count=0.
REQ-040 Reset mid-job discards the job; after rst_n returns high, the block waits in IDLE for a new start.

Verification
REQ-041 DATA_WIDTH=8, IN_DIM=3, memory[i]=i; start with base=0x10, num=2, ready=1 -> vector_out=0x121110 then 0x151413; vectors_complete pulses once; vec_count=2.
REQ-042 ready held low for 5 cycles during PRESENT -> vector_valid stays high, vector_out unchanged, no extra reads.
REQ-043 base=0xFE, num=1 -> reads at 0xFE, 0xFF, 0x00; vector_out packs elements in that order.
REQ-044 num=0 -> no mem_rd_en; vectors_complete pulses one cycle after start; busy high for 1 cycle.
REQ-045 abort in the second FETCH of a num=3 job -> IDLE next cycle, no vectors_complete, vec_count=1; new start accepted afterward.
REQ-046 rst_n low mid-PRESENT -> outputs cleared asynchronously before the next edge; start after release runs a clean job.

Source files
------------

// File: rtl/vector_streamer.sv
// vector_streamer: fetches IN_DIM-element vectors from activation memory and
// presents them one at a time to a downstream feeder with valid/ready handshake.
`default_nettype none

module vector_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int IN_DIM     = 3,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic [ADDR_WIDTH-1:0]        base_addr,
  input  logic [CNT_WIDTH-1:0]         num_vectors,
  output logic                         mem_rd_en,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic [DATA_WIDTH-1:0]        mem_rd_data,
  input  logic                         ready,
  output logic                         vector_valid,
  output logic [IN_DIM*DATA_WIDTH-1:0] vector_out,
  output logic                         vectors_complete,
  output logic                         busy,
  output logic [CNT_WIDTH-1:0]         vec_count
);

  localparam int IDX_W = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IN_DIM - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    PRESENT  = 2'd2,
    COMPLETE = 2'd3
  } state_t;

  state_t                        state_q;
  logic                          mem_rd_en_q;
  logic [ADDR_WIDTH-1:0]         mem_addr_q;
  logic [IDX_W-1:0]              rd_idx_q;
  logic [IDX_W-1:0]              cap_idx_q;
  logic                          cap_vld_q;
  logic [CNT_WIDTH-1:0]          num_q;
  logic [CNT_WIDTH-1:0]          vec_count_q;
  logic [IN_DIM*DATA_WIDTH-1:0]  vec_q;

  logic [CNT_WIDTH:0]            vec_count_d;
  logic                          more_d;

  assign vec_count_d = {1'b0, vec_count_q} + {{CNT_WIDTH{1'b0}}, 1'b1};
  assign more_d      = (vec_count_d < {1'b0, num_q});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      rd_idx_q    <= '0;
      cap_idx_q   <= '0;
      cap_vld_q   <= 1'b0;
      num_q       <= '0;
      vec_count_q <= '0;
      vec_q       <= '0;
    end else if (abort && (state_q != IDLE)) begin
      // Job dropped; vec_count keeps the number of vectors already handed off.
      state_q     <= IDLE;
      mem_rd_en_q <= 1'b0;
      cap_vld_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            vec_count_q <= '0;
            vec_q       <= '0;
            num_q       <= num_vectors;
            if (num_vectors != '0) begin
              state_q     <= FETCH;
              mem_rd_en_q <= 1'b1;
              mem_addr_q  <= base_addr;
              rd_idx_q    <= '0;
              cap_vld_q   <= 1'b0;
            end else begin
              state_q <= COMPLETE;
            end
          end
        end

        FETCH: begin
          // Read data trails its strobe by one cycle, so capture lags issue by one.
          if (cap_vld_q) begin
            for (int k = 0; k < IN_DIM; k++) begin
              if (cap_idx_q == IDX_W'(k)) begin
                vec_q[k*DATA_WIDTH +: DATA_WIDTH] <= mem_rd_data;
              end
            end
            if (cap_idx_q == LAST_IDX) begin
              state_q <= PRESENT;
            end
          end
          cap_vld_q <= mem_rd_en_q;
          cap_idx_q <= rd_idx_q;
          if (mem_rd_en_q) begin
            if (rd_idx_q == LAST_IDX) begin
              mem_rd_en_q <= 1'b0;
            end else begin
              rd_idx_q   <= rd_idx_q + IDX_W'(1);
              mem_addr_q <= mem_addr_q + ADDR_WIDTH'(1);
            end
          end
        end

        PRESENT: begin
          if (ready) begin
            vec_count_q <= vec_count_d[CNT_WIDTH-1:0];
            if (more_d) begin
              state_q     <= FETCH;
              mem_rd_en_q <= 1'b1;
              mem_addr_q  <= mem_addr_q + ADDR_WIDTH'(1);
              rd_idx_q    <= '0;
            end else begin
              state_q <= COMPLETE;
            end
          end
        end

        COMPLETE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_rd_en        = mem_rd_en_q;
  assign mem_addr         = mem_addr_q;
  assign vector_out       = vec_q;
  assign vec_count        = vec_count_q;
  assign vector_valid     = (state_q == PRESENT);
  assign vectors_complete = (state_q == COMPLETE);
  assign busy             = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_vector_streamer.sv
// Self-checking bench for vector_streamer: scoreboard of expected read
// addresses and vectors, checked as the DUT issues reads and transfers vectors.
`default_nettype none

module tb_vector_streamer;

  localparam int DW  = 8;
  localparam int DIM = 3;
  localparam int AW  = 8;
  localparam int CW  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              ready = 1'b0;
  logic [AW-1:0]     base_addr = '0;
  logic [CW-1:0]     num_vectors = '0;
  logic              mem_rd_en;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_rd_data = '0;
  logic              vector_valid;
  logic [DIM*DW-1:0] vector_out;
  logic              vectors_complete;
  logic              busy;
  logic [CW-1:0]     vec_count;

  int checks = 0;
  int errors = 0;
  int complete_cnt = 0;

  logic [AW-1:0]     addr_q[$];
  logic [DIM*DW-1:0] vec_q[$];
  logic [DW-1:0]     mem[256];

  vector_streamer #(
    .DATA_WIDTH(DW),
    .IN_DIM    (DIM),
    .ADDR_WIDTH(AW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .abort           (abort),
    .base_addr       (base_addr),
    .num_vectors     (num_vectors),
    .mem_rd_en       (mem_rd_en),
    .mem_addr        (mem_addr),
    .mem_rd_data     (mem_rd_data),
    .ready           (ready),
    .vector_valid    (vector_valid),
    .vector_out      (vector_out),
    .vectors_complete(vectors_complete),
    .busy            (busy),
    .vec_count       (vec_count)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory, memory[i] = i.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
  end

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_rd_en) begin
        if (addr_q.size() == 0) begin
          errors++;
          $display("FAIL rd_addr: unexpected read at %h, required none", mem_addr);
        end else begin
          logic [AW-1:0] ea;
          ea = addr_q.pop_front();
          checks++;
          if (mem_addr !== ea) begin
            errors++;
            $display("FAIL rd_addr: got %h required %h", mem_addr, ea);
          end
        end
      end
      if (vector_valid && ready) begin
        if (vec_q.size() == 0) begin
          errors++;
          $display("FAIL vector: unexpected transfer %h, required none", vector_out);
        end else begin
          logic [DIM*DW-1:0] ev;
          ev = vec_q.pop_front();
          checks++;
          if (vector_out !== ev) begin
            errors++;
            $display("FAIL vector: got %h required %h", vector_out, ev);
          end
        end
      end
      if (vectors_complete) complete_cnt++;
      if (vector_valid && vectors_complete) begin
        errors++;
        $display("FAIL valid_complete_overlap: got both 1 required not both");
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_job(input logic [AW-1:0] b, input int n);
    logic [AW-1:0]     a;
    logic [DIM*DW-1:0] v;
    a = b;
    for (int i = 0; i < n; i++) begin
      v = '0;
      for (int k = 0; k < DIM; k++) begin
        addr_q.push_back(a);
        v[k*DW +: DW] = mem[a];
        a = a + 8'd1;
      end
      vec_q.push_back(v);
    end
  endtask

  task automatic start_job(input logic [AW-1:0] b, input logic [CW-1:0] n);
    start       = 1'b1;
    base_addr   = b;
    num_vectors = n;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = -1;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (vector_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_complete(output int n);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (vectors_complete) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, vector_valid, vectors_complete, mem_rd_en} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 0000", {busy, vector_valid, vectors_complete, mem_rd_en});
    end
    checks++;
    if ({vector_out, mem_addr, vec_count} !== '0) begin
      errors++;
      $display("FAIL reset_values: got out=%h addr=%h cnt=%h required 0", vector_out, mem_addr, vec_count);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy got %b required 0", busy);
    end
  endtask

  task automatic test_basic();
    int n;
    ready = 1'b1;
    complete_cnt = 0;
    push_job(8'h10, 2);
    start_job(8'h10, 8'd2);
    wait_valid(n);
    checks++;
    if (n !== DIM + 1) begin
      errors++;
      $display("FAIL basic_latency: got %0d required %0d", n, DIM + 1);
    end
    checks++;
    if (vector_out !== 24'h121110) begin
      errors++;
      $display("FAIL basic_first: got %h required 121110", vector_out);
    end
    wait_complete(n);
    checks++;
    if (n < 0) begin
      errors++;
      $display("FAIL basic_complete_timeout: got none required pulse");
    end
    tick();
    checks++;
    if (complete_cnt !== 1 || vec_count !== 8'd2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_end: got pulses=%0d cnt=%0d busy=%b required 1 2 0", complete_cnt, vec_count, busy);
    end
    checks++;
    if (addr_q.size() != 0 || vec_q.size() != 0) begin
      errors++;
      $display("FAIL basic_drain: got addr=%0d vec=%0d left required 0 0", addr_q.size(), vec_q.size());
    end
  endtask

  task automatic test_backpressure();
    int n;
    logic [DIM*DW-1:0] held;
    ready = 1'b0;
    complete_cnt = 0;
    push_job(8'h20, 1);
    start_job(8'h20, 8'd1);
    wait_valid(n);
    checks++;
    if (n < 0) begin
      errors++;
      $display("FAIL bp_valid_timeout: got none required valid");
    end
    held = vector_out;
    start = 1'b1;
    num_vectors = 8'd5;
    for (int i = 0; i < 5; i++) begin
      tick();
      start = 1'b0;
      checks++;
      if (vector_valid !== 1'b1 || vector_out !== held) begin
        errors++;
        $display("FAIL bp_hold: got valid=%b out=%h required 1 %h", vector_valid, vector_out, held);
      end
    end
    ready = 1'b1;
    wait_complete(n);
    tick();
    checks++;
    if (n < 0 || complete_cnt !== 1 || vec_count !== 8'd1) begin
      errors++;
      $display("FAIL bp_end: got wait=%0d pulses=%0d cnt=%0d required >0 1 1", n, complete_cnt, vec_count);
    end
    checks++;
    if (vec_q.size() != 0) begin
      errors++;
      $display("FAIL bp_drain: got %0d left required 0", vec_q.size());
    end
  endtask

  task automatic test_wrap();
    int n;
    ready = 1'b0;
    push_job(8'hFE, 1);
    start_job(8'hFE, 8'd1);
    wait_valid(n);
    checks++;
    if (vector_out !== 24'h00FFFE) begin
      errors++;
      $display("FAIL wrap_vector: got %h required 00fffe", vector_out);
    end
    ready = 1'b1;
    wait_complete(n);
    tick();
    checks++;
    if (n < 0 || addr_q.size() != 0 || vec_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_end: got wait=%0d addr=%0d vec=%0d required >0 0 0", n, addr_q.size(), vec_q.size());
    end
  endtask

  task automatic test_zero();
    ready = 1'b1;
    complete_cnt = 0;
    start_job(8'h70, 8'd0);
    checks++;
    if ({vectors_complete, busy, mem_rd_en, vec_count} !== {3'b110, 8'd0}) begin
      errors++;
      $display("FAIL zero_pulse: got c=%b b=%b rd=%b cnt=%0d required 1 1 0 0", vectors_complete, busy, mem_rd_en, vec_count);
    end
    tick();
    checks++;
    if (vectors_complete !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_idle: got c=%b b=%b required 0 0", vectors_complete, busy);
    end
    tick();
    checks++;
    if (complete_cnt !== 1) begin
      errors++;
      $display("FAIL zero_count: got %0d pulses required 1", complete_cnt);
    end
  endtask

  task automatic test_abort();
    int n;
    bit seen;
    ready = 1'b1;
    complete_cnt = 0;
    push_job(8'h30, 2);
    start_job(8'h30, 8'd3);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (vec_count == 8'd1 && mem_rd_en) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL abort_fetch2_timeout: got none required second fetch");
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({busy, vector_valid, mem_rd_en} !== 3'b000 || vec_count !== 8'd1) begin
      errors++;
      $display("FAIL abort_state: got b=%b v=%b rd=%b cnt=%0d required 0 0 0 1", busy, vector_valid, mem_rd_en, vec_count);
    end
    checks++;
    if (addr_q.size() != 2 || vec_q.size() != 1) begin
      errors++;
      $display("FAIL abort_left: got addr=%0d vec=%0d required 2 1", addr_q.size(), vec_q.size());
    end
    addr_q.delete();
    vec_q.delete();
    tick();
    tick();
    checks++;
    if (complete_cnt !== 0) begin
      errors++;
      $display("FAIL abort_no_pulse: got %0d pulses required 0", complete_cnt);
    end
    start = 1'b1;
    abort = 1'b1;
    base_addr = 8'h40;
    num_vectors = 8'd1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || vec_count !== 8'd1) begin
      errors++;
      $display("FAIL abort_idle_start: got b=%b cnt=%0d required 0 1", busy, vec_count);
    end
    push_job(8'h40, 1);
    start_job(8'h40, 8'd1);
    wait_complete(n);
    tick();
    checks++;
    if (n < 0 || vec_count !== 8'd1 || complete_cnt !== 1 || vec_q.size() != 0) begin
      errors++;
      $display("FAIL abort_restart: got wait=%0d cnt=%0d pulses=%0d left=%0d required >0 1 1 0", n, vec_count, complete_cnt, vec_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int n;
    ready = 1'b0;
    push_job(8'h50, 1);
    start_job(8'h50, 8'd1);
    wait_valid(n);
    checks++;
    if (n < 0) begin
      errors++;
      $display("FAIL rstmid_valid_timeout: got none required valid");
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, vector_valid, mem_rd_en, vectors_complete} !== 4'b0 || {vector_out, mem_addr, vec_count} !== '0) begin
      errors++;
      $display("FAIL rstmid_async: got b=%b v=%b out=%h addr=%h cnt=%0d required all 0", busy, vector_valid, vector_out, mem_addr, vec_count);
    end
    vec_q.delete();
    @(negedge clk) rst_n = 1'b1;
    tick();
    ready = 1'b1;
    complete_cnt = 0;
    push_job(8'h60, 2);
    start_job(8'h60, 8'd2);
    wait_complete(n);
    tick();
    checks++;
    if (n < 0 || vec_count !== 8'd2 || complete_cnt !== 1 || vec_q.size() != 0 || addr_q.size() != 0) begin
      errors++;
      $display("FAIL rstmid_clean_job: got wait=%0d cnt=%0d pulses=%0d vec=%0d addr=%0d required >0 2 1 0 0", n, vec_count, complete_cnt, vec_q.size(), addr_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
